fifo_rd_ctrl: RTL

Read-side controller of the asynchronous FIFO. It runs entirely in the rclk domain and does five things:
- synchronizes the write-domain Gray pointer into rclk;
- keeps the binary and Gray read pointers;
- computes empty, almost-empty and level;
- issues read addresses to fifo_mem;
- registers the memory's combinational read data into a valid/ready output stage for the consumer.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/fifo_rd_ctrl_if.sv | 34 +++
 rtl/fifo_sync.sv | 39 +++
 rtl/fifo_rd_ctrl.sv | 93 +++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_pkg : shared constants, output-stage state and Gray helpers |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package fifo_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 8;
  localparam int unsigned FIFO_ADDR_WIDTH = 8;

  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;

  // Width-agnostic: callers zero-extend to 32 bits and slice the low bits back.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_rd_ctrl_if : read-side pointer, memory and consumer signals |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
interface fifo_rd_ctrl_if
  import fifo_pkg::*;
#(
  parameter int unsigned Data_Width = FIFO_DATA_WIDTH,
  parameter int unsigned Addr_Width = FIFO_ADDR_WIDTH
);
  logic [Addr_Width:0]   wptr_gray;
  logic [Addr_Width:0]   rptr_gray;
  logic [Addr_Width:0]   raddr;
  logic                  r_en;
  logic [Data_Width-1:0] mem_data;
  logic [Data_Width-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic                  empty;
  logic                  almost_empty;
  logic [Addr_Width:0]   rd_level;

  modport master (
    input  wptr_gray, mem_data, rd_ready,
    output rptr_gray, raddr, r_en, rd_data, rd_valid, empty, almost_empty, rd_level
  );

  modport slave (
    output wptr_gray, mem_data, rd_ready,
    input  rptr_gray, raddr, r_en, rd_data, rd_valid, empty, almost_empty, rd_level
  );
endinterface
`default_nettype wire

// File: rtl/fifo_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_sync : N-stage, W-bit synchronizer with async active-low clr |
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
module fifo_sync #(
  parameter int unsigned W = 1,
  parameter int unsigned N = 2
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic [W-1:0] d,
  output logic      [W-1:0] q
);
  logic [W-1:0] stage_q [N];
  logic [W-1:0] stage_d [N];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < int'(N); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[N-1];
endmodule
`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_rd_ctrl : async-FIFO read controller, rclk domain only      |
// | Revision     : 1.0                                               |
// +------------------------------------------------------------------+
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned Data_Width          = FIFO_DATA_WIDTH,
  parameter int unsigned Addr_Width          = FIFO_ADDR_WIDTH,
  parameter int unsigned Depth               = 256,
  parameter int unsigned Sync_Stages         = 2,
  parameter int unsigned Almost_Empty_Thresh = 4
) (
  input  wire logic       rclk,
  input  wire logic       r_rst_n,
  fifo_rd_ctrl_if.master  bus
);
  localparam int unsigned       PW        = Addr_Width + 1;
  localparam logic [PW-1:0]     AE_THRESH = PW'(Almost_Empty_Thresh);

  if ((Depth != (1 << Addr_Width)) || (Sync_Stages < 2)) begin : g_param_check
    $error("fifo_rd_ctrl: Depth must be 2**Addr_Width and Sync_Stages >= 2");
  end

  logic [PW-1:0]         wsync_gray;
  logic [PW-1:0]         wbin;
  logic [PW-1:0]         rd_level;
  logic [PW-1:0]         rbin_inc;
  logic [PW-1:0]         rbin_q, rbin_d;
  logic [PW-1:0]         rptr_gray_q, rptr_gray_d;
  logic [Data_Width-1:0] rd_data_q, rd_data_d;
  out_state_e            state_q, state_d;
  logic                  empty;
  logic                  load;

  fifo_sync #(
    .W (PW),
    .N (Sync_Stages)
  ) u_wptr_sync (
    .clk   (rclk),
    .rst_n (r_rst_n),
    .d     (bus.wptr_gray),
    .q     (wsync_gray)
  );

  always_comb begin
    wbin     = PW'(gray2bin(32'(wsync_gray)));
    rd_level = wbin - rbin_q;
    // Comparing Gray pointers directly keeps a full memory (MSB-only difference) non-empty.
    empty    = (wsync_gray == rptr_gray_q);
    load     = ((state_q == OUT_EMPTY) || bus.rd_ready) && !empty;
    rbin_inc = rbin_q + PW'(1);

    rbin_d      = rbin_q;
    rptr_gray_d = rptr_gray_q;
    rd_data_d   = rd_data_q;
    state_d     = state_q;

    if (load) begin
      rd_data_d   = bus.mem_data;
      rbin_d      = rbin_inc;
      rptr_gray_d = PW'(bin2gray(32'(rbin_inc)));
      state_d     = OUT_VALID;
    end else if ((state_q == OUT_VALID) && bus.rd_ready) begin
      state_d     = OUT_EMPTY;
    end
  end

  always_ff @(posedge rclk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      rbin_q      <= '0;
      rptr_gray_q <= '0;
      rd_data_q   <= '0;
      state_q     <= OUT_EMPTY;
    end else begin
      rbin_q      <= rbin_d;
      rptr_gray_q <= rptr_gray_d;
      rd_data_q   <= rd_data_d;
      state_q     <= state_d;
    end
  end

  assign bus.rptr_gray    = rptr_gray_q;
  assign bus.raddr        = rbin_q;
  assign bus.r_en         = load;
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = (state_q == OUT_VALID);
  assign bus.empty        = empty;
  assign bus.almost_empty = (rd_level <= AE_THRESH);
  assign bus.rd_level     = rd_level;
endmodule
`default_nettype wire
